// File: rtl/tail_aligner.sv
// rtl/tail_aligner.sv - fetch-side aligner: parcel buffer, head-length decode, one instruction per cycle out
// Optional statistics counters enabled by defining TAIL_ALIGNER_STATS_EN.
module tail_aligner #(
    parameter int FETCH_PARCELS = 4,
    parameter int BUF_PARCELS   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [4*FETCH_PARCELS-1:0] fetch_data,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    output logic [31:0]                ins_data,
    output logic [3:0]                 ins_len,
    output logic                       ins_illegal,
    output logic                       ins_valid,
    input  logic                       ins_ready
`ifdef TAIL_ALIGNER_STATS_EN
    ,
    output logic [15:0]                stat_ins,
    output logic [15:0]                stat_illegal
`endif
);

    localparam int CW = $clog2(BUF_PARCELS + 1);
    localparam logic [CW-1:0] READY_MAX = CW'(BUF_PARCELS - FETCH_PARCELS);
    localparam logic [CW-1:0] FETCH_CNT = CW'(FETCH_PARCELS);

    generate
        if (!(FETCH_PARCELS == 1 || FETCH_PARCELS == 2 || FETCH_PARCELS == 4 || FETCH_PARCELS == 8)) begin : g_bad_fetch
            $error("tail_aligner: FETCH_PARCELS must be 1, 2, 4 or 8");
        end
        if (BUF_PARCELS < FETCH_PARCELS + 8) begin : g_bad_buf
            $error("tail_aligner: BUF_PARCELS must be >= FETCH_PARCELS+8");
        end
    endgenerate

    logic [3:0]    parcels_q [BUF_PARCELS];
    logic [3:0]    parcels_d [BUF_PARCELS];
    logic [CW-1:0] count;
    logic [CW-1:0] count_d;

    logic [3:0]    head;
    logic [3:0]    head_len;
    logic          head_illegal;
    logic [CW-1:0] len_cnt;
    logic          avail;
    logic          do_pop;
    logic          do_push;
    logic [CW-1:0] pop_n;
    logic [CW-1:0] base;

    assign head = parcels_q[0];

    always_comb begin
        head_len     = 4'b0001;
        head_illegal = 1'b0;
        casez (head)
            4'b??00, 4'b1?0?: head_len = 4'b0001;
            4'b0001:          head_len = 4'b0010;
            4'b0010:          head_len = 4'b0100;
            4'b0011:          head_len = 4'b1000;
            default:          head_illegal = 1'b1;
        endcase
    end

    // One-hot length read as a binary number is the parcel count itself.
    assign len_cnt = CW'(head_len);
    assign avail   = (count >= len_cnt) && (count != '0);

    assign ins_valid   = avail;
    assign ins_len     = avail ? head_len : 4'b0000;
    assign ins_illegal = avail & head_illegal;

    always_comb begin
        ins_data = '0;
        for (int k = 0; k < 8; k++) begin
            if (avail && (k < int'(len_cnt))) begin
                ins_data[k*4 +: 4] = parcels_q[k];
            end
        end
    end

    assign fetch_ready = (count <= READY_MAX);
    assign do_pop      = avail & ins_ready;
    assign do_push     = fetch_valid & fetch_ready;
    assign pop_n       = do_pop ? len_cnt : '0;
    assign base        = count - pop_n;
    assign count_d     = base + (do_push ? FETCH_CNT : '0);

    // Shift out the popped parcels, then drop the new word right after the surviving tail.
    always_comb begin
        for (int i = 0; i < BUF_PARCELS; i++) begin
            int src;
            int off;
            src          = i + int'(pop_n);
            off          = i - int'(base);
            parcels_d[i] = 4'h0;
            if (src < BUF_PARCELS) begin
                parcels_d[i] = parcels_q[src];
            end
            if (do_push && (off >= 0) && (off < FETCH_PARCELS)) begin
                parcels_d[i] = fetch_data[off*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < BUF_PARCELS; i++) begin
                parcels_q[i] <= 4'h0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            count     <= count_d;
            parcels_q <= parcels_d;
        end
    end

`ifdef TAIL_ALIGNER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ins     <= 16'h0000;
            stat_illegal <= 16'h0000;
        end else if (!flush && do_pop) begin
            if (stat_ins != 16'hFFFF) begin
                stat_ins <= stat_ins + 16'h0001;
            end
            if (head_illegal && (stat_illegal != 16'hFFFF)) begin
                stat_illegal <= stat_illegal + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tail_aligner.sv
// tb/tb_tail_aligner.sv - self-checking bench for tail_aligner (directed table plus randomized model run)
module tb_tail_aligner;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [15:0] fetch_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] ins_data;
    logic [3:0]  ins_len;
    logic        ins_illegal;
    logic        ins_valid;
    logic        ins_ready;
`ifdef TAIL_ALIGNER_STATS_EN
    logic [15:0] stat_ins;
    logic [15:0] stat_illegal;
`endif

    int total = 0;
    int bad   = 0;

    tail_aligner #(.FETCH_PARCELS(4), .BUF_PARCELS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .ins_data    (ins_data),
        .ins_len     (ins_len),
        .ins_illegal (ins_illegal),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready)
`ifdef TAIL_ALIGNER_STATS_EN
        ,
        .stat_ins    (stat_ins),
        .stat_illegal(stat_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [15:0] fd;
        logic        ir;
        logic        fl;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  el;
        logic        ei;
        logic        efr;
    } vec_t;

    vec_t tbl [28];

    logic [3:0] mq [$];
    int         m_stat_ins;
    int         m_stat_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int plen(input logic [3:0] h);
        if (h == 4'd1) return 2;
        if (h == 4'd2) return 4;
        if (h == 4'd3) return 8;
        return 1;
    endfunction

    function automatic logic pill(input logic [3:0] h);
        return h inside {4'd5, 4'd6, 4'd7, 4'd10, 4'd11, 4'd14, 4'd15};
    endfunction

    task automatic rcycle(input logic fv, input logic [15:0] fd, input logic ir, input logic fl);
        int          cnt;
        int          len;
        logic        v;
        logic        fr;
        logic [31:0] d;
        logic [3:0]  h;
        cnt = mq.size();
        h   = (cnt != 0) ? mq[0] : 4'h0;
        len = plen(h);
        v   = (cnt >= len) && (cnt != 0);
        fr  = (cnt <= 12);
        d   = 32'h0;
        if (v) begin
            for (int k = 0; k < len; k++) d = d | (32'(mq[k]) << (4 * k));
        end
        chk("rnd_valid", 32'(ins_valid), 32'(v));
        chk("rnd_data", ins_data, d);
        chk("rnd_len", 32'(ins_len), v ? 32'(len) : 32'h0);
        chk("rnd_illegal", 32'(ins_illegal), 32'(v & pill(h)));
        chk("rnd_fetch_ready", 32'(fetch_ready), 32'(fr));
`ifdef TAIL_ALIGNER_STATS_EN
        chk("rnd_stat_ins", 32'(stat_ins), 32'(m_stat_ins));
        chk("rnd_stat_illegal", 32'(stat_illegal), 32'(m_stat_ill));
`endif
        fetch_valid = fv;
        fetch_data  = fd;
        ins_ready   = ir;
        flush       = fl;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (v && ir) begin
                repeat (len) void'(mq.pop_front());
                if (m_stat_ins < 16'hFFFF) m_stat_ins++;
                if (pill(h) && m_stat_ill < 16'hFFFF) m_stat_ill++;
            end
            if (fv && fr) begin
                for (int k = 0; k < 4; k++) mq.push_back(fd[k*4 +: 4]);
            end
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'h3210, 1'b1, 1'b0, 1'b1, 32'h0,        4'b0001, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h21,       4'b0010, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 16'hAAA3, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b1, 32'hBBBBAAA3, 4'b1000, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 16'h000F, 1'b1, 1'b0, 1'b1, 32'hF,        4'b0001, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h0,        4'b0001, 1'b0, 1'b1};
        tbl[9]  = tbl[8];
        tbl[10] = tbl[8];
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 32'h0,        4'b0001, 1'b0, 1'b1};
        tbl[13] = tbl[12];
        tbl[14] = tbl[12];
        tbl[15] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 32'h0,        4'b0001, 1'b0, 1'b0};
        tbl[16] = tbl[15];
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h0,        4'b0001, 1'b0, 1'b0};
        tbl[18] = tbl[17];
        tbl[19] = tbl[17];
        tbl[20] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h0,        4'b0001, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1};
        tbl[22] = tbl[12];
        tbl[23] = tbl[12];
        tbl[24] = tbl[20];
        tbl[25] = tbl[20];
        tbl[26] = '{1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1};
        tbl[27] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 1'b0, 1'b1};

        rst         = 1'b1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        fetch_data  = 16'h0;
        ins_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(ins_valid), 32'h0);
        chk("reset_len", 32'(ins_len), 32'h0);
        chk("reset_data", ins_data, 32'h0);
        chk("reset_illegal", 32'(ins_illegal), 32'h0);
        chk("reset_fetch_ready", 32'(fetch_ready), 32'h1);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            fetch_valid = tbl[i].fv;
            fetch_data  = tbl[i].fd;
            ins_ready   = tbl[i].ir;
            flush       = tbl[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(ins_valid), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_data", i), ins_data, tbl[i].ed);
            chk($sformatf("vec%0d_len", i), 32'(ins_len), 32'(tbl[i].el));
            chk($sformatf("vec%0d_illegal", i), 32'(ins_illegal), 32'(tbl[i].ei));
            chk($sformatf("vec%0d_fetch_ready", i), 32'(fetch_ready), 32'(tbl[i].efr));
        end

        rst         = 1'b1;
        flush       = 1'b0;
        fetch_valid = 1'b0;
        ins_ready   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_stat_ins = 0;
        m_stat_ill = 0;

        for (int n = 0; n < 3000; n++) begin
            logic        fv;
            logic [15:0] fd;
            logic        ir;
            logic        fl;
            fv = ($urandom_range(0, 99) < 60);
            fd = 16'($urandom);
            ir = ($urandom_range(0, 99) < 65);
            fl = ($urandom_range(0, 99) < 2);
            rcycle(fv, fd, ir, fl);
        end
        rcycle(1'b0, 16'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
